// File: rtl/chien_consts_pkg.sv
// rtl/chien_consts_pkg.sv - GF(2^W) constants and elaboration-time helpers for the Chien search
package chien_consts_pkg;

  localparam int DEF_W    = 10;
  localparam int DEF_T    = 11;
  localparam int DEF_P    = 32;
  localparam int DEF_N    = 1023;
  localparam int DEF_LEN  = 544;
  localparam int DEF_POLY = 'h409;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} chien_state_e;

  function automatic int beats_per_scan(input int len, input int lanes);
    return (len + lanes - 1) / lanes;
  endfunction

  // Shift-and-add product modulo poly; poly carries the x^w term.
  function automatic int gf_mul(input int a, input int b, input int w, input int poly);
    int r;
    int x;
    r = 0;
    x = a;
    for (int i = 0; i < w; i++) begin
      if (b[i]) r = r ^ x;
      x = x << 1;
      if (x[w]) x = x ^ poly;
    end
    return r;
  endfunction

  function automatic int gf_pow(input int alpha, input int e, input int w, input int poly);
    int r;
    int base;
    int ee;
    r    = 1;
    base = alpha;
    ee   = e;
    for (int i = 0; i < 32; i++) begin
      if (ee[0]) r = gf_mul(r, base, w, poly);
      base = gf_mul(base, base, w, poly);
      ee   = ee >> 1;
    end
    return r;
  endfunction

  // Exponent e with alpha^e == alpha^(-m) in a field of the given multiplicative order.
  function automatic int neg_exp(input int m, input int order);
    return (order - (m % order)) % order;
  endfunction

endpackage

// File: rtl/gf_mul_const.sv
// rtl/gf_mul_const.sv - combinational GF(2^W) multiply by an elaboration-time constant
module gf_mul_const
  import chien_consts_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int POLY = DEF_POLY,
  parameter int C    = 1
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] p_o
);

  logic [W-1:0] term [W];

  // Column i is C * x^i; the product is the XOR of the columns selected by a_i.
  for (genvar i = 0; i < W; i++) begin : g_col
    localparam int COL = gf_mul(1 << i, C, W, POLY);
    assign term[i] = a_i[i] ? COL[W-1:0] : '0;
  end

  always_comb begin
    p_o = '0;
    for (int i = 0; i < W; i++) p_o = p_o ^ term[i];
  end

endmodule

// File: rtl/chien_search_stream.sv
// rtl/chien_search_stream.sv - streaming P-lane Chien search with one-entry sigma shadow buffer
module chien_search_stream
  import chien_consts_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int T    = DEF_T,
  parameter int P    = DEF_P,
  parameter int N    = DEF_N,
  parameter int n    = DEF_LEN,
  parameter int POLY = DEF_POLY
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [W-1:0]              sigma_low_i [0:T],
  input  logic                      sigma_valid_i,
  output logic                      sigma_ready_o,
  output logic                      busy_o,
  output logic                      out_valid_o,
  output logic                      last_o,
  output logic [P-1:0]              hit_mask_o,
  output logic [$clog2(N)-1:0]      pos_bus_o [0:P-1],
  output logic                      done_o,
  output logic [$clog2(n+1)-1:0]    root_cnt_o,
  output logic                      fail_o
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(n + 1);
  localparam int B  = beats_per_scan(n, P);
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  chien_state_e  state_q;
  logic [W-1:0]  shd_q [0:T];
  logic          shd_full_q, shd_z0_q;
  logic [CW-1:0] shd_deg_q;
  logic [W-1:0]  r_q [0:T];
  logic [BW-1:0] beat_q;
  logic [CW-1:0] deg_q, fin_deg_q, acc_q, root_cnt_q;
  logic          z0_q, fin_z0_q;
  logic          out_valid_q, last_q, done_q, fail_q;
  logic [P-1:0]  hit_q;
  logic [PW-1:0] pos_q [0:P-1];

  logic [W-1:0]  prod [0:T][0:P-1];
  logic [W-1:0]  r_step [0:T];
  logic [W-1:0]  lane_sum [P];
  logic [P-1:0]  hit_d;
  logic [PW-1:0] pos_d [0:P-1];
  logic [CW-1:0] in_deg, pop, total;
  logic          accept, last_beat, drain;

  for (genvar k = 0; k <= T; k++) begin : g_term
    for (genvar p = 0; p < P; p++) begin : g_lane
      gf_mul_const #(.W(W), .POLY(POLY), .C(gf_pow(2, neg_exp(k * p, N), W, POLY)))
        u_lane (.a_i(r_q[k]), .p_o(prod[k][p]));
    end
    gf_mul_const #(.W(W), .POLY(POLY), .C(gf_pow(2, neg_exp(k * P, N), W, POLY)))
      u_step (.a_i(r_q[k]), .p_o(r_step[k]));
  end

  // Lane p of beat b evaluates sigma at alpha^-(b*P+p); lanes past the codeword are masked.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      int j;
      lane_sum[p] = '0;
      for (int k = 0; k <= T; k++) lane_sum[p] = lane_sum[p] ^ prod[k][p];
      j = int'(beat_q) * P + p;
      hit_d[p] = (j < n) && (lane_sum[p] == '0);
      pos_d[p] = (j < n) ? PW'(n - 1 - j) : '0;
    end
  end

  always_comb begin
    in_deg = '0;
    for (int k = 0; k <= T; k++) if (sigma_low_i[k] != '0) in_deg = CW'(k);
    pop = '0;
    for (int p = 0; p < P; p++) pop = pop + CW'(hit_q[p]);
  end

  assign total     = acc_q + pop;
  assign accept    = sigma_valid_i && !shd_full_q;
  assign last_beat = (state_q == ST_SCAN) && (beat_q == BW'(B - 1));
  assign drain     = shd_full_q && ((state_q == ST_IDLE) || last_beat);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      shd_full_q  <= 1'b0;
      shd_z0_q    <= 1'b0;
      shd_deg_q   <= '0;
      beat_q      <= '0;
      deg_q       <= '0;
      z0_q        <= 1'b0;
      fin_deg_q   <= '0;
      fin_z0_q    <= 1'b0;
      acc_q       <= '0;
      root_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      hit_q       <= '0;
      for (int k = 0; k <= T; k++) begin
        shd_q[k] <= '0;
        r_q[k]   <= '0;
      end
      for (int p = 0; p < P; p++) pos_q[p] <= '0;
    end else begin
      shd_full_q <= accept || (shd_full_q && !drain);
      if (accept) begin
        shd_q     <= sigma_low_i;
        shd_deg_q <= in_deg;
        shd_z0_q  <= (sigma_low_i[0] == '0);
      end

      done_q <= last_q;
      if (last_q) begin
        root_cnt_q <= total;
        fail_q     <= (total != fin_deg_q) || fin_z0_q;
        acc_q      <= '0;
      end else if (out_valid_q) begin
        acc_q <= total;
      end

      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          hit_q       <= '0;
        end
        ST_SCAN: begin
          out_valid_q <= 1'b1;
          hit_q       <= hit_d;
          pos_q       <= pos_d;
          last_q      <= last_beat;
          if (last_beat) begin
            fin_deg_q <= deg_q;
            fin_z0_q  <= z0_q;
            state_q   <= ST_IDLE;
          end else begin
            beat_q <= beat_q + BW'(1);
            r_q    <= r_step;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A full shadow buffer reloads the engine, overriding the return to idle.
      if (drain) begin
        r_q     <= shd_q;
        beat_q  <= '0;
        deg_q   <= shd_deg_q;
        z0_q    <= shd_z0_q;
        state_q <= ST_SCAN;
      end
    end
  end

  assign sigma_ready_o = !shd_full_q;
  assign busy_o        = (state_q == ST_SCAN) || shd_full_q;
  assign out_valid_o   = out_valid_q;
  assign last_o        = last_q;
  assign hit_mask_o    = hit_q;
  assign pos_bus_o     = pos_q;
  assign done_o        = done_q;
  assign root_cnt_o    = root_cnt_q;
  assign fail_o        = fail_q;

endmodule

// File: tb/tb_chien_search_stream.sv
// tb/tb_chien_search_stream.sv - randomized self-checking bench against a polynomial-evaluation model
module tb_chien_search_stream;

  localparam int W = 10, T = 11, P = 32, NF = 1023, NL = 544, POLY = 'h409;
  localparam int B = 17, PW = 10, CW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  sigma_low [0:T];
  logic [W-1:0]  cur_sigma [0:T];
  logic          sigma_valid = 1'b0;
  logic          sigma_ready, busy, out_valid, last_s, done_s, fail_s;
  logic [P-1:0]  hit_mask;
  logic [PW-1:0] pos_bus [0:P-1];
  logic [CW-1:0] root_cnt;

  chien_search_stream #(.W(W), .T(T), .P(P), .N(NF), .n(NL), .POLY(POLY)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sigma_low_i(sigma_low), .sigma_valid_i(sigma_valid),
    .sigma_ready_o(sigma_ready), .busy_o(busy), .out_valid_o(out_valid), .last_o(last_s),
    .hit_mask_o(hit_mask), .pos_bus_o(pos_bus), .done_o(done_s), .root_cnt_o(root_cnt),
    .fail_o(fail_s)
  );

  typedef struct {
    bit [NL-1:0] hits;
    int          cnt;
    int          deg;
    bit          fail;
  } exp_t;

  exp_t exp_q[$];
  exp_t done_exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  int alog [0:NF-1];
  int glog [0:NF];
  int mon_beat = 0, run_len = 0, max_run = 0, done_seen = 0, mj;
  bit last_prev = 1'b0, saw_ready_low = 1'b0, pos_rep;
  logic [P-1:0] em;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(glog[a] + glog[b]) % NF];
  endfunction

  function automatic int eval_at(input logic [W-1:0] s [0:T], input int j);
    int x, acc;
    x = alog[(NF - (j % NF)) % NF];
    acc = 0;
    for (int k = T; k >= 0; k--) acc = gmul(acc, x) ^ int'(s[k]);
    return acc;
  endfunction

  function automatic exp_t model(input logic [W-1:0] s [0:T]);
    exp_t e;
    e.hits = '0;
    e.cnt = 0;
    e.deg = 0;
    for (int k = 0; k <= T; k++) if (s[k] != 0) e.deg = k;
    for (int j = 0; j < NL; j++) begin
      if (eval_at(s, j) == 0) begin
        e.hits[j] = 1'b1;
        e.cnt++;
      end
    end
    e.fail = (e.cnt != e.deg) || (s[0] == 0);
    return e;
  endfunction

  task automatic clear_sigma();
    for (int k = 0; k <= T; k++) cur_sigma[k] = '0;
  endtask

  // sigma = prod (1 + alpha^j x) over m distinct positions j, so root j sits at alpha^-j.
  task automatic build_locator(input int m);
    bit used [NL];
    int cnt, j, x;
    for (int i = 0; i < NL; i++) used[i] = 1'b0;
    clear_sigma();
    cur_sigma[0] = 1;
    cnt = 0;
    while (cnt < m) begin
      j = $urandom_range(0, NL - 1);
      if (!used[j]) begin
        used[j] = 1'b1;
        x = alog[j % NF];
        for (int k = T; k >= 1; k--)
          cur_sigma[k] = cur_sigma[k] ^ W'(gmul(x, int'(cur_sigma[k-1])));
        cnt++;
      end
    end
  endtask

  task automatic send();
    int guard;
    guard = 0;
    sigma_low = cur_sigma;
    sigma_valid = 1'b1;
    while (!sigma_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("send_timeout", guard >= 200, 0);
    exp_q.push_back(model(cur_sigma));
    @(negedge clk);
    sigma_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || done_exp_q.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_timeout", exp_q.size() + done_exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_latency();
    check_eq("lat_e0", out_valid, 0);
    @(negedge clk);
    check_eq("lat_e1", out_valid, 0);
    @(negedge clk);
    check_eq("lat_e2", out_valid, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_beat = 0;
      run_len = 0;
      last_prev = 1'b0;
    end else begin
      if (!sigma_ready) saw_ready_low = 1'b1;
      if (last_prev || done_s) check_eq("done_after_last", done_s, last_prev);
      if (done_s) begin
        done_seen++;
        if (done_exp_q.size() == 0) check_eq("spurious_done", done_s, 0);
        else begin
          mon_e = done_exp_q.pop_front();
          check_eq("root_cnt", root_cnt, mon_e.cnt);
          check_eq("fail", fail_s, mon_e.fail);
        end
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) check_eq("unexpected_beat", out_valid, 0);
        else begin
          mon_e = exp_q[0];
          pos_rep = 1'b0;
          for (int p = 0; p < P; p++) begin
            mj = mon_beat * P + p;
            em[p] = (mj < NL) ? mon_e.hits[mj] : 1'b0;
            if (mj < NL && pos_bus[p] !== PW'(NL - 1 - mj) && !pos_rep) begin
              check_eq("pos", pos_bus[p], NL - 1 - mj);
              pos_rep = 1'b1;
            end
          end
          if (!pos_rep) check_eq("pos", pos_bus[0], NL - 1 - mon_beat * P);
          check_eq("hit_mask", hit_mask, em);
          check_eq("last", last_s, mon_beat == B - 1);
          if (mon_beat == B - 1) begin
            done_exp_q.push_back(exp_q.pop_front());
            mon_beat = 0;
          end else begin
            mon_beat++;
          end
        end
      end else begin
        run_len = 0;
      end
      last_prev = out_valid && last_s;
    end
  end

  initial begin
    int guard, d0;
    alog[0] = 1;
    glog[0] = 0;
    glog[1] = 0;
    for (int i = 1; i < NF; i++) begin
      alog[i] = alog[i-1] << 1;
      if (alog[i] >= 1024) alog[i] = alog[i] ^ POLY;
      glog[alog[i]] = i;
    end
    clear_sigma();
    sigma_low = cur_sigma;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", sigma_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", last_s, 0);
    check_eq("rst_done", done_s, 0);
    check_eq("rst_fail", fail_s, 0);
    check_eq("rst_mask", hit_mask, 0);
    check_eq("rst_pos0", pos_bus[0], 0);
    check_eq("rst_cnt", root_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    clear_sigma(); cur_sigma[0] = 1;
    send();
    check_eq("busy_loaded", busy, 1);
    check_latency();
    wait_idle();
    clear_sigma(); cur_sigma[0] = 1; cur_sigma[1] = 1;
    send(); wait_idle();
    clear_sigma(); cur_sigma[0] = 1; cur_sigma[1] = W'(alog[543]);
    send(); wait_idle();
    clear_sigma(); cur_sigma[0] = 1; cur_sigma[2] = 1;
    send(); wait_idle();
    clear_sigma();
    send(); wait_idle();

    max_run = 0;
    saw_ready_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      build_locator(11);
      send();
    end
    wait_idle();
    check_eq("b2b_run", max_run, 3 * B);
    check_eq("b2b_ready_low", saw_ready_low, 1);

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) build_locator($urandom_range(1, 11));
      else begin
        clear_sigma();
        for (int k = 0; k <= $urandom_range(0, T); k++) cur_sigma[k] = W'($urandom_range(0, NF));
      end
      send();
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    build_locator(5); send();
    build_locator(3); send();
    guard = 0;
    while (mon_beat < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("beat8_timeout", guard >= 100, 0);
    check_eq("shd_full_pre_rst", sigma_ready, 0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    done_exp_q.delete();
    #1;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_last", last_s, 0);
    check_eq("abort_mask", hit_mask, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", sigma_ready, 1);
    check_eq("abort_cnt", root_cnt, 0);
    check_eq("abort_fail", fail_s, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (30) @(negedge clk);
    check_eq("abort_no_done", done_seen - d0, 0);
    check_eq("abort_shd_dropped", busy, 0);
    build_locator(7);
    send();
    check_latency();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
